// File: rtl/anc_frame_sequencer.sv
// Per-frame sequencer for the ANC datapath: sample capture, LMS update, FIR output,
// with stage-wait timeout and overrun status.
module anc_frame_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1500,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    sample_pulse_in,
    input  logic                    nc_on_in,
    input  logic                    clr_status_in,
    output logic                    sampler_ready_out,
    output logic                    err_latch_out,
    output logic                    lms_start_out,
    input  logic                    lms_done_in,
    output logic                    fir_start_out,
    input  logic                    fir_done_in,
    input  logic signed [7:0]       fir_sample_in,
    output logic signed [7:0]       speaker_out,
    output logic                    busy_out,
    output logic                    overrun_out,
    output logic                    timeout_out,
    output logic [CNT_W-1:0]        overrun_count_out
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        StIdle,
        StCapture,
        StLmsWait,
        StFirWait,
        StOutput
    } state_e;

    state_e                 state_q, state_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic                   nc_q, nc_d;
    logic                   timed_out;

    logic                   sampler_ready_q, sampler_ready_d;
    logic                   err_latch_q, err_latch_d;
    logic                   lms_start_q, lms_start_d;
    logic                   fir_start_q, fir_start_d;
    logic signed [7:0]      speaker_q, speaker_d;
    logic                   overrun_q, overrun_d;
    logic                   timeout_q, timeout_d;
    logic [CNT_W-1:0]       ovr_cnt_q, ovr_cnt_d;
    logic                   ovr_evt;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q         <= StIdle;
            wait_q          <= '0;
            nc_q            <= 1'b0;
            sampler_ready_q <= 1'b0;
            err_latch_q     <= 1'b0;
            lms_start_q     <= 1'b0;
            fir_start_q     <= 1'b0;
            speaker_q       <= '0;
            overrun_q       <= 1'b0;
            timeout_q       <= 1'b0;
            ovr_cnt_q       <= '0;
        end else begin
            state_q         <= state_d;
            wait_q          <= wait_d;
            nc_q            <= nc_d;
            sampler_ready_q <= sampler_ready_d;
            err_latch_q     <= err_latch_d;
            lms_start_q     <= lms_start_d;
            fir_start_q     <= fir_start_d;
            speaker_q       <= speaker_d;
            overrun_q       <= overrun_d;
            timeout_q       <= timeout_d;
            ovr_cnt_q       <= ovr_cnt_d;
        end
    end

    // nc_on is captured at acceptance so the CAPTURE branch matches the lms_start already issued.
    always_comb begin
        state_d   = state_q;
        nc_d      = nc_q;
        timed_out = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sample_pulse_in) begin
                    state_d = StCapture;
                    nc_d    = nc_on_in;
                end
            end
            StCapture: state_d = nc_q ? StLmsWait : StFirWait;
            StLmsWait: begin
                if (lms_done_in) begin
                    state_d = StFirWait;
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = StIdle;
                    timed_out = 1'b1;
                end
            end
            StFirWait: begin
                if (fir_done_in) begin
                    state_d = StOutput;
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = StIdle;
                    timed_out = 1'b1;
                end
            end
            StOutput: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        if ((state_d == state_q) && ((state_q == StLmsWait) || (state_q == StFirWait))) begin
            wait_d = wait_q + 1'b1;
        end else begin
            wait_d = '0;
        end
    end

    always_comb begin
        sampler_ready_d = (state_q == StIdle) && sample_pulse_in;
        err_latch_d     = (state_q == StIdle) && sample_pulse_in;
        lms_start_d     = (state_q == StIdle) && sample_pulse_in && nc_on_in;
        fir_start_d     = (state_d == StFirWait) && (state_q != StFirWait);

        speaker_d = speaker_q;
        if (state_q == StOutput) begin
            speaker_d = nc_on_in ? fir_sample_in : '0;
        end
        if (timed_out) begin
            speaker_d = '0;
        end

        ovr_evt   = sample_pulse_in && (state_q != StIdle);
        overrun_d = overrun_q;
        timeout_d = timeout_q;
        ovr_cnt_d = ovr_cnt_q;
        if (clr_status_in) begin
            overrun_d = 1'b0;
            timeout_d = 1'b0;
            ovr_cnt_d = '0;
        end
        // A drop in the clearing cycle still counts as the first of the new window.
        if (ovr_evt) begin
            overrun_d = 1'b1;
            if (clr_status_in) begin
                ovr_cnt_d = CNT_W'(1);
            end else if (ovr_cnt_q != CNT_MAX) begin
                ovr_cnt_d = ovr_cnt_q + 1'b1;
            end
        end
        if (timed_out) begin
            timeout_d = 1'b1;
        end
    end

    assign sampler_ready_out = sampler_ready_q;
    assign err_latch_out     = err_latch_q;
    assign lms_start_out     = lms_start_q;
    assign fir_start_out     = fir_start_q;
    assign speaker_out       = speaker_q;
    assign busy_out          = (state_q != StIdle);
    assign overrun_out       = overrun_q;
    assign timeout_out       = timeout_q;
    assign overrun_count_out = ovr_cnt_q;

endmodule

// File: tb/tb_anc_frame_sequencer.sv
// Directed bench for anc_frame_sequencer: a cycle-by-cycle vector table plus hand-written
// sequences for timeout, overrun saturation and mid-frame reset.
module tb_anc_frame_sequencer;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              sample_pulse_in;
    logic              nc_on_in;
    logic              clr_status_in;
    logic              sampler_ready_out;
    logic              err_latch_out;
    logic              lms_start_out;
    logic              lms_done_in;
    logic              fir_start_out;
    logic              fir_done_in;
    logic signed [7:0] fir_sample_in;
    logic signed [7:0] speaker_out;
    logic              busy_out;
    logic              overrun_out;
    logic              timeout_out;
    logic [7:0]        overrun_count_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_in = ~clk_in;

    anc_frame_sequencer #(
        .TIMEOUT_CYCLES(1500),
        .CNT_W         (8)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .sample_pulse_in  (sample_pulse_in),
        .nc_on_in         (nc_on_in),
        .clr_status_in    (clr_status_in),
        .sampler_ready_out(sampler_ready_out),
        .err_latch_out    (err_latch_out),
        .lms_start_out    (lms_start_out),
        .lms_done_in      (lms_done_in),
        .fir_start_out    (fir_start_out),
        .fir_done_in      (fir_done_in),
        .fir_sample_in    (fir_sample_in),
        .speaker_out      (speaker_out),
        .busy_out         (busy_out),
        .overrun_out      (overrun_out),
        .timeout_out      (timeout_out),
        .overrun_count_out(overrun_count_out)
    );

    // in:  {pulse, nc_on, lms_done, fir_done, clr}
    // out: {sampler_ready, err_latch, lms_start, fir_start, busy, overrun, timeout}
    typedef struct {
        logic [4:0] in;
        logic [7:0] smp;
        logic [6:0] out;
        logic [7:0] cnt;
        logic [7:0] spk;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [4:0] i, input logic [7:0] s, input logic [6:0] o,
                       input logic [7:0] c, input logic [7:0] k);
        vec_t v;
        v.in  = i;
        v.smp = s;
        v.out = o;
        v.cnt = c;
        v.spk = k;
        vecs.push_back(v);
    endtask

    function automatic logic [6:0] ctl();
        return {sampler_ready_out, err_latch_out, lms_start_out, fir_start_out,
                busy_out, overrun_out, timeout_out};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int spk();
        return int'(speaker_out);
    endfunction

    // Minimal nc_on frame with one-cycle done responders; returns in IDLE after OUTPUT.
    task automatic min_frame(input logic signed [7:0] s);
        sample_pulse_in = 1'b1;
        nc_on_in        = 1'b1;
        fir_sample_in   = s;
        @(negedge clk_in);
        sample_pulse_in = 1'b0;
        @(negedge clk_in);
        lms_done_in = 1'b1;
        @(negedge clk_in);
        lms_done_in = 1'b0;
        @(negedge clk_in);
        fir_done_in = 1'b1;
        @(negedge clk_in);
        fir_done_in = 1'b0;
        @(negedge clk_in);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  t_to;
        int  saw_fir;

        rst_in          = 1'b1;
        sample_pulse_in = 1'b0;
        nc_on_in        = 1'b0;
        clr_status_in   = 1'b0;
        lms_done_in     = 1'b0;
        fir_done_in     = 1'b0;
        fir_sample_in   = '0;
        repeat (3) @(negedge clk_in);
        check("reset_ctl", int'(ctl()), 0);
        check("reset_cnt", int'(overrun_count_out), 0);
        check("reset_spk", spk(), 0);
        rst_in = 1'b0;

        // nc_on=1 minimum frame, output 37
        add(5'b11000, 8'sd37,  7'b0000000, 8'd0, 8'sd0);
        add(5'b01000, 8'sd37,  7'b1110100, 8'd0, 8'sd0);
        add(5'b01100, 8'sd37,  7'b0000100, 8'd0, 8'sd0);
        add(5'b01000, 8'sd37,  7'b0001100, 8'd0, 8'sd0);
        add(5'b01010, 8'sd37,  7'b0000100, 8'd0, 8'sd0);
        add(5'b01000, 8'sd37,  7'b0000100, 8'd0, 8'sd0);
        add(5'b01000, 8'sd37,  7'b0000000, 8'd0, 8'sd37);
        // nc_on=0 bypass frame: no lms_start, muted output
        add(5'b10000, -8'sd50, 7'b0000000, 8'd0, 8'sd37);
        add(5'b00000, -8'sd50, 7'b1100100, 8'd0, 8'sd37);
        add(5'b00010, -8'sd50, 7'b0001100, 8'd0, 8'sd37);
        add(5'b00000, -8'sd50, 7'b0000100, 8'd0, 8'sd37);
        add(5'b00000, -8'sd50, 7'b0000000, 8'd0, 8'sd0);
        // stray fir_done outside FIR_WAIT, overrun in OUTPUT, pulse accepted on return to IDLE
        add(5'b11010, 8'sd5,   7'b0000000, 8'd0, 8'sd0);
        add(5'b01010, 8'sd5,   7'b1110100, 8'd0, 8'sd0);
        add(5'b01010, 8'sd5,   7'b0000100, 8'd0, 8'sd0);
        add(5'b01100, 8'sd5,   7'b0000100, 8'd0, 8'sd0);
        add(5'b01010, 8'sd5,   7'b0001100, 8'd0, 8'sd0);
        add(5'b11000, 8'sd5,   7'b0000100, 8'd0, 8'sd0);
        add(5'b11001, 8'sd5,   7'b0000010, 8'd1, 8'sd5);
        add(5'b01000, 8'sd5,   7'b1110100, 8'd0, 8'sd5);
        add(5'b01100, 8'sd5,   7'b0000100, 8'd0, 8'sd5);
        add(5'b01010, 8'sd5,   7'b0001100, 8'd0, 8'sd5);
        add(5'b01000, 8'sd5,   7'b0000100, 8'd0, 8'sd5);
        add(5'b01000, 8'sd5,   7'b0000000, 8'd0, 8'sd5);

        foreach (vecs[i]) begin
            @(negedge clk_in);
            check($sformatf("row%0d_ctl", i), int'(ctl()), int'(vecs[i].out));
            check($sformatf("row%0d_cnt", i), int'(overrun_count_out), int'(vecs[i].cnt));
            check($sformatf("row%0d_spk", i), spk(), int'($signed(vecs[i].spk)));
            {sample_pulse_in, nc_on_in, lms_done_in, fir_done_in, clr_status_in} = vecs[i].in;
            fir_sample_in = vecs[i].smp;
        end
        @(negedge clk_in);
        {sample_pulse_in, nc_on_in, lms_done_in, fir_done_in, clr_status_in} = 5'b0;
        @(negedge clk_in);

        // LMS never answers: timeout 1500 cycles after entering LMS_WAIT (pulse cycle + 2)
        sample_pulse_in = 1'b1;
        nc_on_in        = 1'b1;
        fir_sample_in   = 8'sd37;
        t_to            = 0;
        saw_fir         = 0;
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk_in);
            sample_pulse_in = 1'b0;
            if (fir_start_out) saw_fir = 1;
            if (timeout_out) begin
                t_to = k;
                break;
            end
        end
        check("timeout_latency", t_to, 1502);
        check("timeout_no_fir_start", saw_fir, 0);
        check("timeout_spk", spk(), 0);
        check("timeout_busy", int'(busy_out), 0);

        min_frame(8'sd37);
        check("post_timeout_spk", spk(), 37);
        check("post_timeout_sticky", int'(timeout_out), 1);
        clr_status_in = 1'b1;
        @(negedge clk_in);
        clr_status_in = 1'b0;
        check("timeout_cleared", int'(timeout_out), 0);

        // Overrun saturation while FIR is stalled
        sample_pulse_in = 1'b1;
        fir_sample_in   = -8'sd20;
        @(negedge clk_in);
        sample_pulse_in = 1'b0;
        @(negedge clk_in);
        lms_done_in = 1'b1;
        @(negedge clk_in);
        lms_done_in     = 1'b0;
        sample_pulse_in = 1'b1;
        repeat (300) @(negedge clk_in);
        sample_pulse_in = 1'b0;
        check("sat_cnt", int'(overrun_count_out), 255);
        check("sat_flag", int'(overrun_out), 1);
        check("sat_busy", int'(busy_out), 1);
        clr_status_in   = 1'b1;
        sample_pulse_in = 1'b1;
        @(negedge clk_in);
        clr_status_in   = 1'b0;
        sample_pulse_in = 1'b0;
        check("clr_ovr_flag", int'(overrun_out), 1);
        check("clr_ovr_cnt", int'(overrun_count_out), 1);
        fir_done_in = 1'b1;
        @(negedge clk_in);
        fir_done_in = 1'b0;
        @(negedge clk_in);
        check("sat_frame_spk", spk(), -20);
        check("sat_frame_idle", int'(busy_out), 0);
        clr_status_in = 1'b1;
        @(negedge clk_in);
        clr_status_in = 1'b0;
        check("clr_flag", int'(overrun_out), 0);
        check("clr_cnt", int'(overrun_count_out), 0);

        // Reset while in FIR_WAIT with a held output
        min_frame(8'sd37);
        check("pre_reset_spk", spk(), 37);
        sample_pulse_in = 1'b1;
        @(negedge clk_in);
        sample_pulse_in = 1'b0;
        @(negedge clk_in);
        lms_done_in = 1'b1;
        @(negedge clk_in);
        lms_done_in = 1'b0;
        check("pre_reset_fir_start", int'(fir_start_out), 1);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        check("rst_ctl", int'(ctl()), 0);
        check("rst_cnt", int'(overrun_count_out), 0);
        check("rst_spk", spk(), 0);
        fir_done_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            check($sformatf("rst_ignore_done%0d_ctl", k), int'(ctl()), 0);
            check($sformatf("rst_ignore_done%0d_spk", k), spk(), 0);
        end
        fir_done_in = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
